// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
//   Serial stimulus source for a 1001/010 sequence detector. A parallel
//   pattern is accepted over a valid/ready port and shifted out LSB-first,
//   one bit per clock. Alongside the stream, overlapping 1001 and 010
//   matches are counted so a bench knows how many detector hits to expect.
//
// Parameters
//   WIDTH  max pattern length in bits
//   LEN_W  width of load_len (must hold WIDTH)
//   GAP    idle cycles after each frame (0 = none)
//   CNT_W  width of the saturating exp_cnt
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   loop        (SEQ_GEN_LOOP_EN only) re-emit pattern; sampled on last bit
//   load_valid  pattern offered
//   load_ready  generator idle, pattern will be taken
//   load_data   pattern, bit 0 emitted first
//   load_len    bits to emit; 0 or >WIDTH means WIDTH
//   out_bit     serial data bit
//   out_valid   out_bit is a frame bit this cycle
//   done        pulse coincident with the last frame bit
//   exp_hit     out_bit completes a 1001 or 010 match
//   exp_cnt     running match count for the current frame (saturating)
//
// Build option
//   SEQ_GEN_LOOP_EN  adds the loop input and back-to-back frame repetition.

module seq_pattern_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned GAP   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             loop,
`endif
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             out_bit,
  output logic             out_valid,
  output logic             done,
  output logic             exp_hit,
  output logic [CNT_W-1:0] exp_cnt
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   data_q, data_n;
  logic [WIDTH-1:0]   sreg_q, sreg_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [LEN_W-1:0]   idx_q, idx_n;
  logic [GAP_W-1:0]   gcnt_q, gcnt_n;
  logic [2:0]         hist_q, hist_n;
  logic [1:0]         hlen_q, hlen_n;
  logic               loop_q, loop_n;
  logic               ready_q, ready_n;
  logic               out_bit_q, out_bit_n;
  logic               out_valid_q, out_valid_n;
  logic               done_q, done_n;
  logic               exp_hit_q, exp_hit_n;
  logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_n;

  logic               loop_in;
  logic [LEN_W-1:0]   len_eff;

`ifdef SEQ_GEN_LOOP_EN
  assign loop_in = loop;
`else
  assign loop_in = 1'b0;
`endif

  assign len_eff = ((load_len == '0) || (load_len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : load_len;

  // Emission is funnelled through one block below: each branch only picks
  // the bit to send and whether match history starts fresh.
  logic               emit, fresh, restart, ebit, hit;
  logic [2:0]         hb;
  logic [1:0]         hl;
  logic [CNT_W-1:0]   cb;

  always_comb begin
    state_n     = state_q;
    data_n      = data_q;
    sreg_n      = sreg_q;
    len_n       = len_q;
    idx_n       = idx_q;
    gcnt_n      = gcnt_q;
    hist_n      = hist_q;
    hlen_n      = hlen_q;
    loop_n      = loop_q;
    exp_cnt_n   = exp_cnt_q;
    ready_n     = 1'b0;
    out_bit_n   = 1'b0;
    out_valid_n = 1'b0;
    done_n      = 1'b0;
    exp_hit_n   = 1'b0;
    emit        = 1'b0;
    fresh       = 1'b0;
    restart     = 1'b0;
    ebit        = 1'b0;
    hit         = 1'b0;
    hb          = '0;
    hl          = '0;
    cb          = '0;

    case (state_q)
      S_IDLE: begin
        ready_n = 1'b1;
        if (load_valid && ready_q) begin
          data_n  = load_data;
          len_n   = len_eff;
          sreg_n  = load_data >> 1;
          ebit    = load_data[0];
          idx_n   = LEN_W'(1);
          done_n  = (len_eff == LEN_W'(1));
          emit    = 1'b1;
          fresh   = 1'b1;
          ready_n = 1'b0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // idx counts bits already sent; equality means this cycle holds the last one.
        if (idx_q == len_q) begin
          loop_n = loop_in;
          if (GAP > 0) begin
            state_n = S_GAP;
            gcnt_n  = GAP_W'(GAP - 1);
          end else if (loop_in) begin
            restart = 1'b1;
          end else begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end
        end else begin
          ebit   = sreg_q[0];
          sreg_n = sreg_q >> 1;
          idx_n  = idx_q + LEN_W'(1);
          done_n = ((idx_q + LEN_W'(1)) == len_q);
          emit   = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) begin
          if (loop_q) begin
            restart = 1'b1;
          end else begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end
        end else begin
          gcnt_n = gcnt_q - GAP_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Looped frames replay the captured pattern but keep history and count.
    if (restart) begin
      ebit    = data_q[0];
      sreg_n  = data_q >> 1;
      idx_n   = LEN_W'(1);
      done_n  = (len_q == LEN_W'(1));
      emit    = 1'b1;
      state_n = S_SHIFT;
    end

    // hlen gates the match so cleared history never forms a false 010/1001.
    if (emit) begin
      hb  = fresh ? 3'b000 : hist_q;
      hl  = fresh ? 2'd0 : hlen_q;
      cb  = fresh ? '0 : exp_cnt_q;
      hit = ((hl == 2'd3) && (hb == 3'b100) && ebit) ||
            ((hl >= 2'd2) && (hb[1:0] == 2'b01) && !ebit);
      out_valid_n = 1'b1;
      out_bit_n   = ebit;
      exp_hit_n   = hit;
      exp_cnt_n   = (hit && (cb != '1)) ? cb + CNT_W'(1) : cb;
      hist_n      = {hb[1:0], ebit};
      hlen_n      = (hl == 2'd3) ? 2'd3 : hl + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      sreg_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      gcnt_q      <= '0;
      hist_q      <= '0;
      hlen_q      <= '0;
      loop_q      <= 1'b0;
      ready_q     <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      exp_hit_q   <= 1'b0;
      exp_cnt_q   <= '0;
    end else begin
      state_q     <= state_n;
      data_q      <= data_n;
      sreg_q      <= sreg_n;
      len_q       <= len_n;
      idx_q       <= idx_n;
      gcnt_q      <= gcnt_n;
      hist_q      <= hist_n;
      hlen_q      <= hlen_n;
      loop_q      <= loop_n;
      ready_q     <= ready_n;
      out_bit_q   <= out_bit_n;
      out_valid_q <= out_valid_n;
      done_q      <= done_n;
      exp_hit_q   <= exp_hit_n;
      exp_cnt_q   <= exp_cnt_n;
    end
  end

  assign load_ready = ready_q;
  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign exp_hit    = exp_hit_q;
  assign exp_cnt    = exp_cnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed loads, a queue-based expectation of
// every output cycle, and literal checks of the documented example frames.
module tb_seq_pattern_gen;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int GAP   = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic [LEN_W-1:0] load_len = '0;
`ifdef SEQ_GEN_LOOP_EN
  logic             loop = 1'b0;
`endif
  logic             load_ready;
  logic             out_bit;
  logic             out_valid;
  logic             done;
  logic             exp_hit;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W),
    .GAP  (GAP),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_GEN_LOOP_EN
    .loop      (loop),
`endif
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_len  (load_len),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .done      (done),
    .exp_hit   (exp_hit),
    .exp_cnt   (exp_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  typedef struct packed {
    logic             valid;
    logic             b;
    logic             done;
    logic             hit;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  rec_t             mq[$];
  rec_t             cur = '0;
  bit               m_on = 1'b0;
  bit               m_ready = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_stream[$];
  logic [WIDTH-1:0] m_data = '0;
  int               m_len = 0;

  // Append one frame (plus trailing idle cycles) to the expected stream.
  function automatic void push_frame(input bit fresh);
    rec_t             r;
    int               n;
    logic [WIDTH-1:0] d;
    if (fresh) begin
      m_stream.delete();
      m_cnt = '0;
    end
    d = m_data;
    for (int i = 0; i < m_len; i++) begin
      r = '0;
      r.b = d[0];
      d = d >> 1;
      m_stream.push_back(r.b);
      n = m_stream.size();
      r.hit = ((n >= 4) && m_stream[n-4] == 1'b1 && m_stream[n-3] == 1'b0 &&
               m_stream[n-2] == 1'b0 && m_stream[n-1] == 1'b1) ||
              ((n >= 3) && m_stream[n-3] == 1'b0 && m_stream[n-2] == 1'b1 &&
               m_stream[n-1] == 1'b0);
      if (r.hit && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      r.valid = 1'b1;
      r.done  = (i == m_len - 1);
      r.cnt   = m_cnt;
      mq.push_back(r);
    end
    for (int g = 0; g < GAP; g++) begin
      r = '0;
      r.cnt = m_cnt;
      mq.push_back(r);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1;
      mq.delete();
      m_cnt = '0;
      cur = '0;
      m_ready = 1'b0;
    end else if (m_on) begin
`ifdef SEQ_GEN_LOOP_EN
      if (cur.done && loop) push_frame(1'b0);
`endif
      if (load_valid && m_ready) begin
        m_data = load_data;
        m_len  = (load_len == 0 || load_len > WIDTH) ? WIDTH : int'(load_len);
        push_frame(1'b1);
      end
      if (mq.size() > 0) begin
        cur = mq.pop_front();
        m_ready = 1'b0;
      end else begin
        cur = '0;
        cur.cnt = m_cnt;
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare + frame observation ----------------
  logic [31:0] obs_bits = '0;
  logic [31:0] obs_hits = '0;
  int          obs_n = 0;
  int          obs_done_n = 0;
  int          obs_done_idx = -1;

  always @(negedge clk) begin
    if (m_on) begin
      check("cycle {ready,valid,bit,done,hit,cnt}",
            32'({load_ready, out_valid, out_bit, done, exp_hit, exp_cnt}),
            32'({m_ready, cur.valid, cur.b, cur.done, cur.hit, cur.cnt}));
      if (out_valid) begin
        obs_bits = obs_bits | (32'(out_bit) << obs_n);
        obs_hits = obs_hits | (32'(exp_hit) << obs_n);
        if (done) begin
          obs_done_n++;
          obs_done_idx = obs_n;
        end
        obs_n++;
      end
    end
  end

  task automatic clear_obs();
    obs_bits = '0;
    obs_hits = '0;
    obs_n = 0;
    obs_done_n = 0;
    obs_done_idx = -1;
  endtask

  // Returns at the negedge of the cycle holding bit 0.
  task automatic do_load(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
    int w = 0;
    @(negedge clk);
    while (!load_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("load_ready_wait", 32'(w < 200), 32'd1);
    clear_obs();
    load_data  = d;
    load_len   = l;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Returns just after the negedge of the cycle carrying done.
  task automatic wait_done();
    int w = 0;
    @(negedge clk);
    while (done !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", 32'(done), 32'd1);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rdy;

    // 1: reset for 3 cycles, ready on the 2nd cycle after release
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_release_c1", 32'(load_ready), 32'd0);
    check("cnt_after_reset", 32'(exp_cnt), 32'd0);
    @(negedge clk);
    check("ready_release_c2", 32'(load_ready), 32'd1);

    // 2: 16'h692A, full length
    do_load(16'h692A, 5'd16);
    wait_done();
    check("t2_bits", obs_bits, 32'h0000_692A);
    check("t2_hits", obs_hits, 32'h0000_1B54);
    check("t2_cnt", 32'(exp_cnt), 32'd7);
    check("t2_done_idx", 32'(obs_done_idx), 32'd15);
    check("t2_nbits", 32'(obs_n), 32'd16);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rdy[2-k] = load_ready;
    end
    check("t2_gap_ready", 32'(rdy), 32'b001);
    check("t2_cnt_hold", 32'(exp_cnt), 32'd7);

    // 3: 1,0,0,1
    do_load(16'h0009, 5'd4);
    wait_done();
    check("t3_bits", obs_bits, 32'h9);
    check("t3_hits", obs_hits, 32'h8);
    check("t3_cnt", 32'(exp_cnt), 32'd1);
    check("t3_done_idx", 32'(obs_done_idx), 32'd3);

    // 4: len 0 means WIDTH; a mid-frame load offer is ignored
    do_load(16'hFFFF, 5'd0);
    repeat (4) @(negedge clk);
    load_data  = 16'h0009;
    load_len   = 5'd4;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    wait_done();
    check("t4_bits", obs_bits, 32'h0000_FFFF);
    check("t4_nbits", 32'(obs_n), 32'd16);
    check("t4_cnt", 32'(exp_cnt), 32'd0);

    // 5: reset during bit 5 aborts, then a clean restart
    do_load(16'h692A, 5'd16);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_valid_after_rst", 32'(out_valid), 32'd0);
    check("t5_done_after_rst", 32'(done), 32'd0);
    check("t5_cnt_after_rst", 32'(exp_cnt), 32'd0);
    check("t5_bits_before_abort", 32'(obs_n), 32'd6);
    check("t5_no_done", 32'(obs_done_n), 32'd0);
    rst = 1'b0;
    do_load(16'h692A, 5'd16);
    wait_done();
    check("t5_bits", obs_bits, 32'h0000_692A);
    check("t5_cnt", 32'(exp_cnt), 32'd7);

`ifdef SEQ_GEN_LOOP_EN
    // 6: two looped frames; one extra hit spans the boundary (1,1,0 | 0,1)
    loop = 1'b1;
    do_load(16'h692A, 5'd16);
    wait_done();
    @(posedge clk);
    #1 loop = 1'b0;
    wait_done();
    check("t6_done_pulses", 32'(obs_done_n), 32'd2);
    check("t6_cnt", 32'(exp_cnt), 32'd15);
    check("t6_bits", obs_bits, 32'h692A_692A);
`endif

    repeat (6) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
